// File: rtl/axi_master_port_pkg.sv
// Shared AXI types for the single-outstanding master port: channel structs,
// burst/response encodings and the port FSM state enum.
package axi_master_port_pkg;

   localparam int AMP_ID_W_WIDTH     = 4;
   localparam int AMP_ID_R_WIDTH     = 4;
   localparam int AMP_ADDR_WIDTH     = 16;
   localparam int AMP_DATA_WIDTH     = 32;
   localparam int AMP_BYTE_WIDTH     = 8;
   localparam int AMP_STRB_WIDTH     = AMP_DATA_WIDTH / AMP_BYTE_WIDTH;
   localparam int AMP_ID_WIDTH       = 4;
   localparam int AMP_DEST_WIDTH     = 4;
   localparam int AMP_USER_WIDTH     = 4;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_DONE
   } amp_state_e;

   // Master-driven channels
   typedef struct packed {
      logic [AMP_ID_W_WIDTH-1:0] aw_id;
      logic [AMP_ADDR_WIDTH-1:0] aw_addr;
      logic [7:0]                aw_len;
      logic [2:0]                aw_size;
      logic [1:0]                aw_burst;
      logic                      aw_valid;
      logic [AMP_DATA_WIDTH-1:0] w_data;
      logic [AMP_STRB_WIDTH-1:0] w_strb;
      logic                      w_last;
      logic                      w_valid;
`ifdef TID_PRESENT
      logic [AMP_ID_WIDTH-1:0]   t_id;
`endif
`ifdef TDEST_PRESENT
      logic [AMP_DEST_WIDTH-1:0] t_dest;
`endif
`ifdef TUSER_PRESENT
      logic [AMP_USER_WIDTH-1:0] t_user;
`endif
      logic                      b_ready;
      logic [AMP_ID_R_WIDTH-1:0] ar_id;
      logic [AMP_ADDR_WIDTH-1:0] ar_addr;
      logic [7:0]                ar_len;
      logic [2:0]                ar_size;
      logic [1:0]                ar_burst;
      logic                      ar_valid;
      logic                      r_ready;
   } axi_mosi_t;

   // Responder-driven channels
   typedef struct packed {
      logic                      aw_ready;
      logic                      w_ready;
      logic [AMP_ID_W_WIDTH-1:0] b_id;
      logic [1:0]                b_resp;
      logic                      b_valid;
      logic                      ar_ready;
      logic [AMP_ID_R_WIDTH-1:0] r_id;
      logic [AMP_DATA_WIDTH-1:0] r_data;
      logic [1:0]                r_resp;
      logic                      r_last;
      logic                      r_valid;
   } axi_miso_t;

   // Numerically larger response code is the more severe one
   function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_master_port.sv
// Single-outstanding AXI4 initiator: one INCR burst per command, write data
// streamed straight through (no buffering), read data streamed straight out.
// Channel struct field widths come from the package; the parameters below
// must stay equal to the package widths.
module axi_master_port
   import axi_master_port_pkg::*;
#(
   parameter int ID_W_WIDTH     = AMP_ID_W_WIDTH,
   parameter int ID_R_WIDTH     = AMP_ID_R_WIDTH,
   parameter int ADDR_WIDTH     = AMP_ADDR_WIDTH,
   parameter int AXI_DATA_WIDTH = AMP_DATA_WIDTH,
   parameter int BYTE_WIDTH     = AMP_BYTE_WIDTH,
   localparam int ID_MAX        = (ID_W_WIDTH > ID_R_WIDTH) ? ID_W_WIDTH : ID_R_WIDTH,
   localparam int STRB_W        = AXI_DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_write_i,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
   input  logic [7:0]                cmd_len_i,
   input  logic [ID_MAX-1:0]         cmd_id_i,
   input  logic [AXI_DATA_WIDTH-1:0] wdata_i,
   input  logic [STRB_W-1:0]         wstrb_i,
   input  logic                      wvalid_i,
   output logic                      wready_o,
   output logic [AXI_DATA_WIDTH-1:0] rdata_o,
   output logic                      rvalid_o,
   input  logic                      rready_i,
   output logic                      rlast_o,
   output logic                      done_o,
   output logic [1:0]                resp_o,
   output axi_mosi_t                 out_mosi_o,
   input  axi_miso_t                 out_miso_i
);

   localparam int         BYTES = AXI_DATA_WIDTH / 8;
   localparam logic [2:0] SIZE  = 3'($clog2(BYTES));

   amp_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [ID_MAX-1:0]     id_q, id_d;
   logic [7:0]            beat_q, beat_d;
   logic [1:0]            acc_q, acc_d;
   logic [1:0]            resp_q, resp_d;
   logic [1:0]            r_worst;
   logic                  last_beat;

   // Burst end measured from the 4 KiB page start; wide enough for 256 beats
   logic [23:0]           burst_end;
   logic                  crosses_4k;

   assign burst_end  = 24'(cmd_addr_i[11:0]) + ((24'(cmd_len_i) + 24'd1) * 24'(BYTES));
   assign crosses_4k = (burst_end > 24'd4096);
   assign last_beat  = (beat_q == len_q);
   assign rdata_o    = out_miso_i.r_data;
   // Completion response is live during DONE and then held until the next one
   assign resp_o     = (state_q == ST_DONE) ? acc_q : resp_q;

   logic unused_bid;
   assign unused_bid = ^out_miso_i.b_id;

   // State and command context registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         id_q    <= '0;
         beat_q  <= '0;
         acc_q   <= AXI_RESP_OKAY;
         resp_q  <= AXI_RESP_OKAY;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         id_q    <= id_d;
         beat_q  <= beat_d;
         acc_q   <= acc_d;
         resp_q  <= resp_d;
      end
   end

   // Next state, beat counter, response accumulation and channel outputs
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      id_d        = id_q;
      beat_d      = beat_q;
      acc_d       = acc_q;
      resp_d      = resp_q;
      r_worst     = resp_worst(acc_q, out_miso_i.r_resp);
      cmd_ready_o = 1'b0;
      wready_o    = 1'b0;
      rvalid_o    = 1'b0;
      rlast_o     = 1'b0;
      done_o      = 1'b0;

      // Address/control fields track the latched command; only valids gate them
      out_mosi_o          = '0;
      out_mosi_o.aw_id    = id_q[ID_W_WIDTH-1:0];
      out_mosi_o.aw_addr  = addr_q;
      out_mosi_o.aw_len   = len_q;
      out_mosi_o.aw_size  = SIZE;
      out_mosi_o.aw_burst = AXI_BURST_INCR;
      out_mosi_o.w_data   = wdata_i;
      out_mosi_o.w_strb   = wstrb_i;
      out_mosi_o.w_last   = last_beat;
      out_mosi_o.ar_id    = id_q[ID_R_WIDTH-1:0];
      out_mosi_o.ar_addr  = addr_q;
      out_mosi_o.ar_len   = len_q;
      out_mosi_o.ar_size  = SIZE;
      out_mosi_o.ar_burst = AXI_BURST_INCR;

      unique case (state_q)
         ST_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               addr_d = cmd_addr_i;
               len_d  = cmd_len_i;
               id_d   = cmd_id_i;
               beat_d = '0;
               acc_d  = AXI_RESP_OKAY;
               // A burst crossing a 4 KiB page is refused without touching the bus
               if (crosses_4k) begin
                  acc_d   = AXI_RESP_SLVERR;
                  state_d = ST_DONE;
               end else begin
                  state_d = cmd_write_i ? ST_AW : ST_AR;
               end
            end
         end
         ST_AW: begin
            out_mosi_o.aw_valid = 1'b1;
            if (out_miso_i.aw_ready) state_d = ST_W;
         end
         ST_W: begin
            out_mosi_o.w_valid = wvalid_i;
            wready_o           = out_miso_i.w_ready;
            if (wvalid_i && out_miso_i.w_ready) begin
               beat_d = beat_q + 8'd1;
               if (last_beat) state_d = ST_B;
            end
         end
         ST_B: begin
            out_mosi_o.b_ready = 1'b1;
            if (out_miso_i.b_valid) begin
               acc_d   = out_miso_i.b_resp;
               state_d = ST_DONE;
            end
         end
         ST_AR: begin
            out_mosi_o.ar_valid = 1'b1;
            if (out_miso_i.ar_ready) state_d = ST_R;
         end
         ST_R: begin
            out_mosi_o.r_ready = rready_i;
            rvalid_o           = out_miso_i.r_valid;
            rlast_o            = out_miso_i.r_last;
            if (out_miso_i.r_valid && rready_i) begin
               // Protocol violations force SLVERR but never mask a DECERR
               if ((out_miso_i.r_id != id_q[ID_R_WIDTH-1:0]) ||
                   (out_miso_i.r_last != last_beat))
                  r_worst = resp_worst(r_worst, AXI_RESP_SLVERR);
               acc_d  = r_worst;
               beat_d = beat_q + 8'd1;
               if (last_beat) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done_o  = 1'b1;
            resp_d  = acc_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_master_port.sv
// Directed bench for axi_master_port: a small behavioural AXI memory
// responder, a table of commands with hand-computed results, and
// hand-written sequences for AW back-pressure and mid-burst reset.
module tb_axi_master_port;
   import axi_master_port_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_write_i = 1'b0;
   logic [15:0] cmd_addr_i = '0;
   logic [7:0]  cmd_len_i = '0;
   logic [3:0]  cmd_id_i = '0;
   logic [31:0] wdata_i;
   logic [3:0]  wstrb_i = 4'hF;
   logic        wvalid_i = 1'b0, wready_o;
   logic [31:0] rdata_o;
   logic        rvalid_o, rready_i = 1'b1, rlast_o, done_o;
   logic [1:0]  resp_o;
   axi_mosi_t   mosi;
   axi_miso_t   miso;

   axi_master_port dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
      .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_id_i(cmd_id_i),
      .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
      .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i), .rlast_o(rlast_o),
      .done_o(done_o), .resp_o(resp_o), .out_mosi_o(mosi), .out_miso_i(miso)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- responder model ----------------
   int          aw_stall_cfg = 0, rbad_cfg = -1;
   logic [1:0]  bresp_cfg = 2'b00;
   logic        ridbad_cfg = 1'b0;
   logic [31:0] smem [256];
   logic [7:0]  s_wptr, s_rptr;
   logic [8:0]  s_rcnt;
   logic [3:0]  s_rid, s_bid;
   logic        s_bpend, s_ract;
   int          s_ridx, aw_wait;

   always_comb begin
      miso          = '0;
      miso.aw_ready = (aw_wait == 0);
      miso.w_ready  = 1'b1;
      miso.b_valid  = s_bpend;
      miso.b_resp   = bresp_cfg;
      miso.b_id     = s_bid;
      miso.ar_ready = 1'b1;
      miso.r_valid  = s_ract;
      miso.r_data   = smem[s_rptr];
      miso.r_last   = (s_rcnt == 9'd1);
      miso.r_resp   = (s_ridx == rbad_cfg) ? 2'b11 : 2'b00;
      miso.r_id     = s_rid ^ {3'b000, ridbad_cfg};
   end

   always @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s_wptr <= '0; s_rptr <= '0; s_rcnt <= '0; s_rid <= '0; s_bid <= '0;
         s_bpend <= 1'b0; s_ract <= 1'b0; s_ridx <= 0; aw_wait <= 0;
      end else begin
         if (mosi.aw_valid && !miso.aw_ready) aw_wait <= aw_wait - 1;
         else if (!mosi.aw_valid) aw_wait <= aw_stall_cfg;
         if (mosi.aw_valid && miso.aw_ready) begin
            s_wptr <= mosi.aw_addr[9:2];
            s_bid  <= mosi.aw_id;
         end
         if (mosi.w_valid && miso.w_ready) begin
            smem[s_wptr] <= mosi.w_data;
            s_wptr <= s_wptr + 8'd1;
            if (mosi.w_last) s_bpend <= 1'b1;
         end
         if (s_bpend && mosi.b_ready) s_bpend <= 1'b0;
         if (mosi.ar_valid && miso.ar_ready) begin
            s_rptr <= mosi.ar_addr[9:2];
            s_rcnt <= 9'(mosi.ar_len) + 9'd1;
            s_ract <= 1'b1;
            s_rid  <= mosi.ar_id;
            s_ridx <= 0;
         end else if (s_ract && mosi.r_ready) begin
            s_rptr <= s_rptr + 8'd1;
            s_rcnt <= s_rcnt - 9'd1;
            s_ridx <= s_ridx + 1;
            if (s_rcnt == 9'd1) s_ract <= 1'b0;
         end
      end
   end

   // ---------------- bus monitors ----------------
   int          aw_tot = 0, ar_tot = 0, w_tot = 0, r_tot = 0, done_tot = 0;
   int          wlast_at = -1, rlast_at = -1;
   logic [7:0]  aw_len_seen = '0, ar_len_seen = '0;
   logic [4:0]  aw_sb_seen = '0, ar_sb_seen = '0;   // {size, burst}
   logic [31:0] rbuf [64];
   logic [31:0] wbase = '0;
   int          wstart = 0;

   // Write stream: beat k of the current command carries wbase + k
   always_comb wdata_i = wbase + 32'(w_tot - wstart);

   always @(posedge clk_i) begin
      if (mosi.aw_valid && miso.aw_ready) begin
         aw_tot <= aw_tot + 1; aw_len_seen <= mosi.aw_len; aw_sb_seen <= {mosi.aw_size, mosi.aw_burst};
      end
      if (mosi.ar_valid && miso.ar_ready) begin
         ar_tot <= ar_tot + 1; ar_len_seen <= mosi.ar_len; ar_sb_seen <= {mosi.ar_size, mosi.ar_burst};
      end
      if (mosi.w_valid && miso.w_ready) begin
         if (mosi.w_last) wlast_at <= w_tot;
         w_tot <= w_tot + 1;
      end
      if (rvalid_o && rready_i) begin
         rbuf[r_tot % 64] <= rdata_o;
         if (rlast_o) rlast_at <= r_tot;
         r_tot <= r_tot + 1;
      end
      if (done_o) done_tot <= done_tot + 1;
   end

   // ---------------- command driver ----------------
   // Cycle 0 is the command handshake cycle; cyc is the cycle in which done_o is seen.
   task automatic run_cmd(input logic wr, input logic [15:0] a, input logic [7:0] l,
                          input logic [3:0] id, input bit tog,
                          output int cyc, output logic [1:0] rsp, output bit got);
      @(negedge clk_i);
      cmd_write_i = wr; cmd_addr_i = a; cmd_len_i = l; cmd_id_i = id;
      cmd_valid_i = 1'b1; wvalid_i = wr; rready_i = 1'b1;
      @(posedge clk_i);
      #1 cmd_valid_i = 1'b0;
      cyc = 0; got = 1'b0; rsp = 2'b00;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk_i);
         cyc++;
         if (tog) rready_i = ~rready_i;
         if (done_o) begin got = 1'b1; rsp = resp_o; end
      end
      wvalid_i = 1'b0; rready_i = 1'b1;
   endtask

   task automatic aw_monitor(output int stall, output int bad, output int vcyc);
      stall = 0; bad = 0; vcyc = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_i);
         if (mosi.aw_valid) vcyc++;
         if (mosi.aw_valid && !miso.aw_ready) begin
            stall++;
            if (mosi.aw_addr !== 16'h0040 || mosi.aw_len !== 8'd1) bad++;
            if (wready_o !== 1'b0) bad++;
         end
      end
   endtask

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  len;
      logic [3:0]  id;
      bit          tog;
      logic [1:0]  bresp;
      int          rbad;
      logic        ridbad;
      int          exp_cyc;   // 0: latency not checked
      logic [1:0]  exp_resp;
      bit          exp_bus;
      logic [31:0] wbase;
   } vec_t;

   vec_t        vecs [10];
   logic [31:0] sh_mem [256];

   initial begin
      int cyc, stall, bad, vcyc, aw0, ar0, w0, r0, d0, mism;
      logic [1:0] rsp;
      bit got, hit;
      vec_t v;

      //            wr    addr      len  id  tog bresp rbad ridb cyc resp  bus wbase
      vecs[0] = '{1'b1, 16'h0010, 8'd3, 4'd3, 0, 2'b00, -1, 1'b0, 7, 2'b00, 1, 32'hA000_0000};
      vecs[1] = '{1'b0, 16'h0010, 8'd3, 4'd3, 1, 2'b00, -1, 1'b0, 0, 2'b00, 1, 32'h0};
      vecs[2] = '{1'b1, 16'h0FF8, 8'd3, 4'd4, 0, 2'b00, -1, 1'b0, 1, 2'b10, 0, 32'hEEEE_0000};
      vecs[3] = '{1'b0, 16'h0FF8, 8'd3, 4'd4, 0, 2'b00, -1, 1'b0, 1, 2'b10, 0, 32'h0};
      vecs[4] = '{1'b1, 16'h0100, 8'd1, 4'd5, 0, 2'b10, -1, 1'b0, 5, 2'b10, 1, 32'hB000_0000};
      vecs[5] = '{1'b0, 16'h0100, 8'd1, 4'd5, 0, 2'b00,  1, 1'b0, 4, 2'b11, 1, 32'h0};
      vecs[6] = '{1'b0, 16'h0010, 8'd3, 4'd9, 0, 2'b00, -1, 1'b0, 6, 2'b00, 1, 32'h0};
      vecs[7] = '{1'b1, 16'h0FF0, 8'd3, 4'd1, 0, 2'b00, -1, 1'b0, 7, 2'b00, 1, 32'hC000_0000};
      vecs[8] = '{1'b0, 16'h0100, 8'd0, 4'd6, 0, 2'b00, -1, 1'b1, 3, 2'b10, 1, 32'h0};
      vecs[9] = '{1'b0, 16'h0FF0, 8'd3, 4'd2, 0, 2'b00, -1, 1'b0, 6, 2'b00, 1, 32'h0};

      // Reset state
      repeat (3) @(negedge clk_i);
      chk("rst cmd_ready", cmd_ready_o, 1);
      chk("rst wready", wready_o, 0);
      chk("rst rvalid", rvalid_o, 0);
      chk("rst done", done_o, 0);
      chk("rst resp", resp_o, 0);
      chk("rst valids", {mosi.aw_valid, mosi.w_valid, mosi.b_ready, mosi.ar_valid, mosi.r_ready}, 0);
      rst_n_i = 1'b1;
      repeat (2) @(negedge clk_i);

      for (int i = 0; i < 10; i++) begin
         v = vecs[i];
         bresp_cfg = v.bresp; rbad_cfg = v.rbad; ridbad_cfg = v.ridbad;
         wbase = v.wbase; wstart = w_tot;
         aw0 = aw_tot; ar0 = ar_tot; w0 = w_tot; r0 = r_tot;
         run_cmd(v.wr, v.addr, v.len, v.id, v.tog, cyc, rsp, got);
         chk($sformatf("v%0d done seen", i), got, 1);
         if (v.exp_cyc > 0) chk($sformatf("v%0d done cycle", i), cyc, v.exp_cyc);
         chk($sformatf("v%0d resp", i), rsp, v.exp_resp);
         @(negedge clk_i);
         chk($sformatf("v%0d done one-shot", i), done_o, 0);
         chk($sformatf("v%0d cmd_ready after", i), cmd_ready_o, 1);
         chk($sformatf("v%0d resp held", i), resp_o, v.exp_resp);
         if (v.wr) begin
            chk($sformatf("v%0d aw count", i), aw_tot - aw0, v.exp_bus ? 1 : 0);
            chk($sformatf("v%0d w beats", i), w_tot - w0, v.exp_bus ? int'(v.len) + 1 : 0);
            if (v.exp_bus) begin
               chk($sformatf("v%0d awlen", i), aw_len_seen, v.len);
               chk($sformatf("v%0d aw size/burst", i), aw_sb_seen, {3'd2, 2'b01});
               chk($sformatf("v%0d wlast beat", i), wlast_at - w0, v.len);
               for (int b = 0; b <= int'(v.len); b++)
                  sh_mem[(int'(v.addr[9:2]) + b) % 256] = v.wbase + 32'(b);
            end
         end else begin
            chk($sformatf("v%0d ar count", i), ar_tot - ar0, v.exp_bus ? 1 : 0);
            chk($sformatf("v%0d r beats", i), r_tot - r0, v.exp_bus ? int'(v.len) + 1 : 0);
            if (v.exp_bus) begin
               chk($sformatf("v%0d arlen", i), ar_len_seen, v.len);
               chk($sformatf("v%0d ar size/burst", i), ar_sb_seen, {3'd2, 2'b01});
               chk($sformatf("v%0d rlast beat", i), rlast_at - r0, v.len);
               mism = 0;
               for (int b = 0; b <= int'(v.len); b++)
                  if (rbuf[(r0 + b) % 64] !== sh_mem[(int'(v.addr[9:2]) + b) % 256]) mism++;
               chk($sformatf("v%0d rdata mismatches", i), mism, 0);
            end
         end
      end
      bresp_cfg = 2'b00; rbad_cfg = -1; ridbad_cfg = 1'b0;

      // AW back-pressure: awready withheld for 5 cycles
      aw_stall_cfg = 5;
      wbase = 32'hD000_0000; wstart = w_tot; w0 = w_tot;
      repeat (2) @(negedge clk_i);
      fork
         run_cmd(1'b1, 16'h0040, 8'd1, 4'd7, 0, cyc, rsp, got);
         aw_monitor(stall, bad, vcyc);
      join
      chk("stall done seen", got, 1);
      chk("stall done cycle", cyc, 10);
      chk("stall resp", rsp, 2'b00);
      chk("stall cycles", stall, 5);
      chk("stall awvalid cycles", vcyc, 6);
      chk("stall aw stability/wready", bad, 0);
      chk("stall w beats", w_tot - w0, 2);
      aw_stall_cfg = 0;
      repeat (2) @(negedge clk_i);

      // Reset asserted while W beat 2 is on the bus
      wbase = 32'hDEAD_0000; wstart = w_tot; w0 = w_tot;
      @(negedge clk_i);
      cmd_write_i = 1'b1; cmd_addr_i = 16'h0200; cmd_len_i = 8'd3; cmd_id_i = 4'd2;
      cmd_valid_i = 1'b1; wvalid_i = 1'b1;
      @(posedge clk_i);
      #1 cmd_valid_i = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 20 && !hit; k++) begin
         @(negedge clk_i);
         if (w_tot - w0 == 2 && mosi.w_valid) hit = 1'b1;
      end
      chk("mid-reset reached beat 2", hit, 1);
      d0 = done_tot;
      rst_n_i = 1'b0;
      #1;
      chk("mid-reset valids", {mosi.aw_valid, mosi.w_valid, mosi.b_ready, mosi.ar_valid, mosi.r_ready}, 0);
      chk("mid-reset wready", wready_o, 0);
      chk("mid-reset rvalid", rvalid_o, 0);
      chk("mid-reset done", done_o, 0);
      wvalid_i = 1'b0;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      repeat (8) @(negedge clk_i);
      chk("post-reset cmd_ready", cmd_ready_o, 1);
      chk("post-reset no done", done_tot - d0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
